// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the UART TX write arbiter and its
// round-robin picker.
//   arb_state_t   : arbiter FSM state (IDLE / OWN)
//   DEF_*         : default parameter values for the arbiter
//   idx_width()   : width of an index into an N-entry vector (minimum 1)
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_B         = 8;
  localparam int DEF_MAX_BURST = 16;

  // $clog2(2) is 1 but $clog2(1) is 0; keep at least one bit so index
  // registers are never zero-width.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Searches req_i circularly starting at
// ptr_i+1 and returns the first set index as a one-hot vector and as a
// binary index. Shared with the RX-side dispatcher.
//   req_i   in  N   request vector
//   ptr_i   in  PW  index of the last served requester
//   grant_o out N   one-hot pick (all zero when nothing requested)
//   idx_o   out PW  binary index of the pick
//   found_o out 1   at least one request was present
// ---------------------------------------------------------------------------
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit (smallest
    // offset after ptr_i) is the one left standing.
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin write arbiter sharing one UART TX FIFO among N byte-stream
// requesters. A requester owns the FIFO write port for a burst that ends on
// its last-marked byte or after MAX_BURST bytes, whichever comes first.
// Bursts are separated by one IDLE arbitration cycle.
//   clk          in  1    clock
//   reset        in  1    asynchronous, active-high reset
//   req_valid    in  N    lane i has a byte
//   req_data     in  N*B  lane i = bits [i*B +: B]
//   req_last     in  N    byte on lane i ends its burst
//   req_ready    out N    byte on lane i accepted this cycle (with valid)
//   grant        out N    one-hot owner, zero when idle
//   fifo_full    in  1    FIFO full flag
//   fifo_wr      out 1    FIFO write strobe
//   fifo_w_data  out B    FIFO write data
//   busy         out 1    a grant is held
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int B         = DEF_B,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*B-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic           busy
);

  localparam int PW = idx_width(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  // Registered state
  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Picker results (only consumed in IDLE)
  logic [N-1:0]  pick_grant;
  logic [PW-1:0] pick_idx;
  logic          pick_found;

  // Owner-lane control
  logic owner_valid;
  logic owner_last;
  logic xfer;
  logic cap_hit;
  logic end_burst;

  rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // -------------------------------------------------------------------------
  // Lane mux. The one-hot grant masks every lane and the results are OR-ed,
  // so the write data depends only on the registered grant and req_data.
  // In IDLE the mask is zero and the output is a clean 0.
  // -------------------------------------------------------------------------
  logic [B-1:0] lane_masked [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane_masked[gi] = req_data[gi*B +: B] & {B{grant_q[gi]}};
    end
  endgenerate

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < N; i++) begin
      fifo_w_data = fifo_w_data | lane_masked[i];
    end
  end

  // -------------------------------------------------------------------------
  // Transfer qualification. grant_q is all-zero outside OWN, so masking with
  // it already restricts these to the owner lane.
  // -------------------------------------------------------------------------
  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign xfer        = (state_q == OWN) && owner_valid && !fifo_full;
  // The byte being transferred now is number burst_cnt_q+1.
  assign cap_hit     = (burst_cnt_q == CW'(MAX_BURST - 1));
  // last and the cap on the same byte collapse into one release.
  assign end_burst   = xfer && (owner_last || cap_hit);

  assign fifo_wr   = xfer;
  assign req_ready = ((state_q == OWN) && !fifo_full) ? grant_q : '0;
  assign grant     = grant_q;
  assign busy      = (state_q == OWN);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OWN;
          grant_d     = pick_grant;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      OWN: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
        if (end_burst) begin
          state_d  = IDLE;
          grant_d  = '0;
          // Next search starts just after the requester that was served.
          rr_ptr_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. rr_ptr starts at N-1 so requester 0 wins first.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= PW'(N - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: each test pushes the expected {grant, byte} sequence,
// lane models feed bytes to the arbiter, and an independent monitor pops
// and compares on every FIFO write.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_w_data;
  logic        busy;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [11:0] exp_q [$];      // {one-hot grant, byte}
  logic [8:0]  lmem [4][32];   // per-lane {last, byte}
  int          head [4];
  int          tail [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < 4; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = lmem[i][head[i]][7:0];
        req_last[i]         = lmem[i][head[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_lanes();
  endtask

  task automatic load_lane(input int lane, input logic [7:0] base, input int n, input int last_every);
    logic [7:0] d;
    logic       l;
    for (int k = 0; k < n; k++) begin
      d = base + 8'(k);
      l = (((k + 1) % last_every) == 0) || (k == n - 1);
      lmem[lane][tail[lane]] = {l, d};
      tail[lane]++;
    end
  endtask

  task automatic exp_push(input int lane, input logic [7:0] d);
    logic [3:0] g;
    g = 4'b0001 << lane;
    exp_q.push_back({g, d});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, {28'd0, grant}, 32'd0);
    check({tag, "_fifo_wr"}, {31'd0, fifo_wr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    clear_lanes();
    exp_q.delete();
    fifo_full = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    wr_count = 0;
  endtask

  task automatic wait_drain(input string tag);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && (busy === 1'b0);
      for (int i = 0; i < 4; i++) begin
        if (head[i] != tail[i]) done = 0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes still expected, required 0 within 300 cycles", tag, exp_q.size());
    end
  endtask

  // Lane models: a byte accepted at a rising edge is retired and the next
  // one presented just after that edge.
  initial begin
    logic [3:0] ack;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      ack = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ack[i] && head[i] < tail[i]) head[i]++;
      end
      drive_lanes();
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && fifo_wr === 1'b1) begin
        wr_count++;
        check("wr_while_full", {31'd0, fifo_full}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got grant %b data %h, required no write", grant, fifo_w_data);
        end else begin
          e = exp_q.pop_front();
          check("write", {20'd0, grant, fifo_w_data}, {20'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int gaps;
    int w;
    int n;
    reset     = 1'b0;
    fifo_full = 1'b0;

    // ---- Reset: asserted mid-cycle, all outputs quiet; requester 0 first
    #3;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_lane(i, 8'(i + 1), 1, 1);
      exp_push(i, 8'(i + 1));
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("first_grant", {28'd0, grant}, 32'h1);
    wait_drain("reset_rr");

    // ---- Single burst on requester 2
    do_reset();
    load_lane(2, 8'h41, 3, 3);
    exp_push(2, 8'h41);
    exp_push(2, 8'h42);
    exp_push(2, 8'h43);
    @(posedge clk);
    @(negedge clk);
    check("sb_idle_grant", {28'd0, grant}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("sb_grant", {28'd0, grant}, 32'h4);
    bcnt = (busy === 1'b1) ? 1 : 0;
    repeat (8) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    check("sb_busy_cycles", bcnt, 3);
    wait_drain("single");

    // ---- Fairness: requesters 0 and 1, two 2-byte bursts each
    do_reset();
    load_lane(0, 8'h10, 4, 2);
    load_lane(1, 8'h20, 4, 2);
    exp_push(0, 8'h10); exp_push(0, 8'h11);
    exp_push(1, 8'h20); exp_push(1, 8'h21);
    exp_push(0, 8'h12); exp_push(0, 8'h13);
    exp_push(1, 8'h22); exp_push(1, 8'h23);
    bcnt = 0;
    gaps = 0;
    w    = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (w > 0 && w < 8 && busy !== 1'b1) gaps++;
      if (fifo_wr === 1'b1) w++;
    end
    check("fair_busy_cycles", bcnt, 8);
    check("fair_idle_gaps", gaps, 3);
    wait_drain("fair");

    // ---- Backpressure: full for 5 cycles after 2 of 4 bytes
    do_reset();
    load_lane(1, 8'hA0, 4, 4);
    for (int k = 0; k < 4; k++) exp_push(1, 8'hA0 + 8'(k));
    n = 0;
    while (wr_count < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("bp_reached_two", wr_count, 2);
    #2;
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_fifo_wr", {31'd0, fifo_wr}, 32'd0);
      check("bp_req_ready", {28'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    @(negedge clk);
    check("bp_resume_wr", {31'd0, fifo_wr}, 32'd1);
    wait_drain("backpressure");

    // ---- Burst cap: requester 3 streams 20, requester 1 interleaves
    do_reset();
    load_lane(3, 8'h30, 20, 20);
    for (int k = 0; k < 16; k++) exp_push(3, 8'h30 + 8'(k));
    exp_push(1, 8'h50);
    exp_push(1, 8'h51);
    for (int k = 16; k < 20; k++) exp_push(3, 8'h30 + 8'(k));
    @(posedge clk);
    @(posedge clk);
    #2;
    load_lane(1, 8'h50, 2, 2);
    wait_drain("burst_cap");

    // ---- Reset mid-burst after 2 of 5 bytes
    do_reset();
    load_lane(0, 8'h60, 5, 5);
    exp_push(0, 8'h60);
    exp_push(0, 8'h61);
    n = 0;
    while (wr_count < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("mid_reached_two", wr_count, 2);
    #2;
    reset = 1'b1;
    clear_lanes();
    #1;
    check_idle_outputs("mid_reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    load_lane(2, 8'h77, 1, 1);
    exp_push(2, 8'h77);
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin write arbiter that shares one UART transmit FIFO (B-bit words, registered `full` flag, write ignored when full) among N byte-stream requesters. It grants one requester at a time for a burst of up to MAX_BURST bytes or until that requester marks its last byte. It drives the FIFO write port directly and never writes while the FIFO reports full. It sits between the on-chip clients (CPU MMIO port, debug console, DMA) and the TX FIFO feeding the UART transmitter.

## Interface
- `N`, 4: number of requesters (2..8)
- `B`, 8: data word width; matches FIFO word width
- `MAX_BURST`, 16: maximum bytes per grant before forced release (1..255)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  N  requester i has a byte on its data lane
- `req_data`  in  N*B  lane i = bits [i*B +: B]
- `req_last`  in  N  byte on lane i is the final byte of its burst
- `req_ready`  out  N  byte on lane i accepted this cycle when `req_valid[i]` is also high
- `grant`  out  N  one-hot current owner; all-zero when idle
- `fifo_full`  in  1  FIFO full flag
- `fifo_wr`  out  1  FIFO write strobe
- `fifo_w_data`  out  B  FIFO write data
- `busy`  out  1  a grant is held

## Operation
- FSM states are IDLE and OWN.
- **IDLE**
  - If no requester is valid, remain in IDLE.
  - Otherwise pick the first index with `req_valid` high, searching circularly from `rr_ptr+1`.
  - Register `grant` to the picked index, clear `burst_cnt`, and go to OWN.
  - No transfer happens in IDLE.
- **OWN** (owner `g`)
  - `req_ready[g] = ~fifo_full`; all other `req_ready` bits are 0.
  - A transfer is `req_valid[g] & ~fifo_full`. On a transfer: `fifo_wr = 1`, `fifo_w_data` = lane g, and `burst_cnt` increments.
  - Gaps where `req_valid[g]` is low are allowed; the grant is held.
  - On a transfer with `req_last[g]=1`, or the transfer that makes `burst_cnt == MAX_BURST`:
    - next state is IDLE
    - `rr_ptr <= g`
    - `grant` clears
- Requester contract: once `req_valid[i]` is high, `req_data` and `req_last` stay stable until accepted. The arbiter does not check this.
- `burst_cnt` is `$clog2(MAX_BURST+1)` bits wide and never exceeds MAX_BURST.
- `rr_ptr` resets to N-1, so requester 0 has first priority after reset.
- `busy` = (state == OWN).
- `fifo_w_data` = lane g whenever in OWN; it is don't-care when `fifo_wr=0` but must not be X in OWN.

## Timing
- Reset values: state IDLE, `grant=0`, `req_ready=0`, `fifo_wr=0`, `busy=0`, `burst_cnt=0`, `rr_ptr=N-1`.
- Reset mid-burst aborts immediately. A byte whose transfer cycle has not completed is not written.
- `fifo_wr`, `fifo_w_data` and `req_ready` are combinational from registered state, `req_valid` and `fifo_full`. There are no combinational paths from `req_data` to control signals.
- Arbitration latency: `req_valid` seen in IDLE at cycle t gives `grant` at t+1, and the first possible write at t+1.
- Bursts are separated by exactly one IDLE cycle. Peak throughput is k bytes in k+1 cycles.
- `fifo_full` high stalls with no write and `req_ready=0`. The write resumes in the cycle `fifo_full` falls.
- `req_last` and the MAX_BURST limit on the same byte produce a single release.
- A single valid requester is re-granted after one IDLE cycle; round-robin never blocks a lone requester.
- Requesters that become valid while another owns the grant wait. The worst-case wait is (N-1)*(MAX_BURST+1) cycles plus FIFO stall time.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_t` {IDLE, OWN}
  - default parameter constants
- Sub-module `rr_picker`:
  - combinational, N-bit request vector plus `rr_ptr` in, one-hot grant plus `found` out
  - reusable by the RX-side dispatcher
- Top-level holds the FSM, `burst_cnt`, `rr_ptr` and the lane mux.

## Test plan
- **Reset:** assert `reset` mid-cycle, no requests → all outputs 0; `rr_ptr` = 3 → first grant goes to requester 0 when all 4 request.
- **Single burst:** requester 2 sends 0x41,0x42,0x43 (last on 0x43), `fifo_full=0` → `grant=4'b0100` from cycle 1, three consecutive `fifo_wr` with those bytes, `busy` falls the cycle after 0x43.
- **Fairness:** requesters 0 and 1 each hold continuous 2-byte bursts → ownership alternates 0,1,0,1, with one idle cycle between bursts and no byte lost.
- **Backpressure:** `fifo_full=1` for 5 cycles in the middle of a 4-byte burst → no `fifo_wr` and `req_ready=0` while full; the remaining bytes are written in order once full drops.
- **Burst cap:** MAX_BURST=16, requester 3 streams 20 bytes with last on byte 20, requester 1 also valid → release after byte 16, requester 1 burst, then requester 3 resumes with byte 17.
- **Reset mid-burst:** reset after 2 of 5 bytes → `grant=0`, `fifo_wr=0` immediately; a fresh request afterwards is granted normally.
